fetch_buffer: RTL and testbench

Instruction fetch front-end for the RV-MAGIC RV32I core. It sits between the instruction memory (IMEM) and the core's decode stage. It drives sequential word fetches to IMEM and buffers the returned instructions, each tagged with its PC, in a small FIFO. It hands them to decode through a valid/ready handshake and discards all buffered and in-flight instructions when the core redirects the PC on a branch or jump.

---
 rtl/fetch_buffer.sv | 119 +++++++++++
 tb/tb_fetch_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// ============================================================================
//  Module      : fetch_buffer
//  Description : RV32I instruction fetch front-end. Issues sequential IMEM
//                word reads and queues {inst, pc} pairs for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int unsigned            DEPTH      = 4,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] I_MEM_addr,
    output logic                  I_MEM_memRead,
    input  logic [INST_WIDTH-1:0] I_MEM_dataOut,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  resp_pending_q, resp_pending_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [INST_WIDTH-1:0] mem_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];

    logic [CNT_W:0]        occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Reserve a slot for the in-flight response; a same-cycle pop is not credited.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, resp_pending_q};
    assign issue     = !rst && !redirect_valid && (occupancy < C_DEPTH);
    assign push      = resp_pending_q && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    assign I_MEM_addr    = fetch_pc_q;
    assign I_MEM_memRead = issue;
    assign inst_valid    = (count_q != '0);
    assign inst          = mem_inst_q[rd_ptr_q];
    assign inst_pc       = mem_pc_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pending_d = 1'b0;
        resp_pc_d      = resp_pc_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d     = fetch_pc_q + ADDR_WIDTH'(4);
                resp_pending_d = 1'b1;
                resp_pc_d      = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q     <= RESET_PC;
            resp_pending_q <= 1'b0;
            resp_pc_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            resp_pending_q <= resp_pending_d;
            resp_pc_q      <= resp_pc_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            if (push) begin
                mem_inst_q[wr_ptr_q] <= I_MEM_dataOut;
                mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Self-checking bench for fetch_buffer against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] I_MEM_addr;
    logic        I_MEM_memRead;
    logic [31:0] I_MEM_dataOut = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_fpc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_q[$];

    fetch_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .I_MEM_addr     (I_MEM_addr),
        .I_MEM_memRead  (I_MEM_memRead),
        .I_MEM_dataOut  (I_MEM_dataOut),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h5A5A_3C3C;
    endfunction

    // Synchronous IMEM: garbage when not read so stray sampling is visible.
    always @(posedge clk) begin
        if (I_MEM_memRead) I_MEM_dataOut <= imem_word(I_MEM_addr);
        else               I_MEM_dataOut <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc  = RESET_PC;
        m_pend = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance model, cross the edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit exp_rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
        exp_rd = !redir && ((m_q.size() + int'(m_pend)) < DEPTH);
        chk("memRead", {31'd0, I_MEM_memRead}, {31'd0, exp_rd});
        chk("addr", I_MEM_addr, m_fpc);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            chk("inst_pc", inst_pc, m_q[0]);
            chk("inst", inst, imem_word(m_q[0]));
        end
        if (redir) begin
            m_q.delete();
            m_fpc  = {rpc[31:2], 2'b00};
            m_pend = 1'b0;
        end else begin
            if (rdy && m_q.size() != 0) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            if (exp_rd) begin
                m_pend_pc = m_fpc;
                m_pend    = 1'b1;
                m_fpc     = m_fpc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic random_run(input int n, input int ready_pct, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            bit r;
            r = ($urandom_range(99) < redir_pct);
            step(r, $urandom, ($urandom_range(99) < ready_pct));
        end
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_memRead", {31'd0, I_MEM_memRead}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_addr", I_MEM_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;

        // Streaming from reset with ready held
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // Backpressure from reset, then in-flight redirect on the 5th cycle
        @(negedge clk); rst = 1'b1; model_reset(); @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        chk("pre_redir_valid", {31'd0, inst_valid}, 32'd1);
        step(1'b1, 32'h0000_0103, 1'b1);
        chk("post_redir_addr", I_MEM_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Fill fully under backpressure, then drain
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Redirect while the head is offered and decode is ready
        step(1'b1, 32'h0000_0200, 1'b1);
        chk("flush_empty", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Address wrap and pointer wrap over many pushes
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

        // Back-to-back redirects: the last one wins
        step(1'b1, 32'h0000_1000, 1'b1);
        step(1'b1, 32'h0000_2002, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        random_run(300, 70, 5);
        random_run(200, 25, 3);

        // Asynchronous reset mid-stream, between edges
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_memRead", {31'd0, I_MEM_memRead}, 32'd0);
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_addr", I_MEM_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        random_run(300, 60, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
